// File: rtl/rle_symbolizer.sv
// rtl/rle_symbolizer.sv - JPEG run-length symbolizer: zigzag coefficients in, (run, size, amplitude) symbols out
//
// Purpose: consumes one 8x8 block of quantized coefficients in zigzag order
// (index 0 = DC) and produces one symbol per DC difference / nonzero AC, plus
// ZRL (15,0) for zero runs of 16 or more and EOB (0,0) when the block ends in
// zeros. The output is a single register stage with valid/ready handshake.
//
// Ports:
//   clk_in           clock, rising edge
//   rst_n_in         asynchronous active-low reset
//   dc_clear_in      pulse: zero the DC predictor (applies to a same-cycle DC)
//   coeff_in         signed quantized coefficient, zigzag order
//   coeff_valid_in   coeff_in valid
//   coeff_ready_out  coefficient accepted on valid && ready
//   sym_valid_out    symbol registers valid
//   sym_ready_in     downstream accepts the symbol on valid && ready
//   sym_run_out      zero run 0..15
//   sym_size_out     magnitude category 0..11
//   sym_amp_out      amplitude bits, right-aligned, upper bits zero
//   sym_is_dc_out    symbol is the DC difference
//   sym_last_out     final symbol of the block
module rle_symbolizer #(
  parameter int COEFF_W = 11
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      dc_clear_in,
  input  logic signed [COEFF_W-1:0] coeff_in,
  input  logic                      coeff_valid_in,
  output logic                      coeff_ready_out,
  output logic                      sym_valid_out,
  input  logic                      sym_ready_in,
  output logic [3:0]                sym_run_out,
  output logic [3:0]                sym_size_out,
  output logic [11:0]               sym_amp_out,
  output logic                      sym_is_dc_out,
  output logic                      sym_last_out
);

  // DC difference needs one extra bit of headroom.
  localparam int DW = COEFF_W + 1;
  localparam logic signed [DW-1:0] AC_MAX = DW'(1023);
  localparam logic signed [DW-1:0] AC_MIN = DW'(-1023);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    ZRL_FLUSH = 2'd1,
    HELD      = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  run;
    logic [3:0]  size;
    logic [11:0] amp;
    logic        is_dc;
    logic        last;
  } sym_t;

  function automatic sym_t mk_sym(input logic [3:0] r, input logic [3:0] s,
                                  input logic [11:0] a, input logic d,
                                  input logic l);
    sym_t t;
    t.run   = r;
    t.size  = s;
    t.amp   = a;
    t.is_dc = d;
    t.last  = l;
    return t;
  endfunction

  // Magnitude category: position of the highest set bit of |v|.
  function automatic logic [3:0] cat_f(input logic signed [DW-1:0] v);
    logic [DW-1:0] mag;
    logic [3:0]    c;
    mag = v[DW-1] ? -v : v;
    c   = 4'd0;
    for (int i = 0; i < DW; i++) begin
      if (mag[i]) c = 4'(i + 1);
    end
    return c;
  endfunction

  // Negative values are sent in ones'-complement form: (v-1) truncated to size bits.
  function automatic logic [11:0] amp_f(input logic signed [DW-1:0] v,
                                        input logic [3:0] size);
    logic [DW-1:0] raw;
    logic [DW-1:0] mask;
    raw  = v[DW-1] ? (v - 1'b1) : v;
    mask = ~({DW{1'b1}} << size);
    return 12'(raw & mask);
  endfunction

  state_t                    state_q, state_d;
  logic [5:0]                idx_q, idx_d;
  logic [5:0]                zrun_q, zrun_d;
  logic signed [COEFF_W-1:0] prev_dc_q, prev_dc_d;
  logic [3:0]                hold_size_q, hold_size_d;
  logic [11:0]               hold_amp_q, hold_amp_d;
  logic                      hold_last_q, hold_last_d;
  logic                      sym_valid_q, sym_valid_d;
  sym_t                      sym_q, sym_d;

  logic                      out_free;
  logic                      coeff_fire;
  logic signed [DW-1:0]      coeff_ext;
  logic signed [DW-1:0]      dc_pred_ext;
  logic signed [DW-1:0]      dc_diff;
  logic signed [DW-1:0]      ac_sat;
  logic [3:0]                dc_size, ac_size;
  logic [11:0]               dc_amp, ac_amp;
  logic [5:0]                zrun_rem;

  assign out_free        = !sym_valid_q || sym_ready_in;
  assign coeff_ready_out = (state_q == RUN) && out_free;
  assign coeff_fire      = coeff_valid_in && coeff_ready_out;

  assign coeff_ext   = {coeff_in[COEFF_W-1], coeff_in};
  assign dc_pred_ext = dc_clear_in ? '0 : {prev_dc_q[COEFF_W-1], prev_dc_q};
  assign dc_diff     = coeff_ext - dc_pred_ext;
  assign ac_sat      = (coeff_ext > AC_MAX) ? AC_MAX :
                       (coeff_ext < AC_MIN) ? AC_MIN : coeff_ext;
  assign dc_size     = cat_f(dc_diff);
  assign dc_amp      = amp_f(dc_diff, dc_size);
  assign ac_size     = cat_f(ac_sat);
  assign ac_amp      = amp_f(ac_sat, ac_size);
  assign zrun_rem    = zrun_q - 6'd16;

  // The first ZRL is loaded on the same edge that accepts the coefficient, so
  // each ZRL costs exactly one stall cycle. ZRL_FLUSH means more ZRLs remain
  // after the one in the output register; HELD means the held coefficient is
  // the next thing to load.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    zrun_d      = zrun_q;
    prev_dc_d   = prev_dc_q;
    hold_size_d = hold_size_q;
    hold_amp_d  = hold_amp_q;
    hold_last_d = hold_last_q;
    sym_valid_d = sym_valid_q;
    sym_d       = sym_q;

    if (dc_clear_in) prev_dc_d = '0;
    if (out_free)    sym_valid_d = 1'b0;

    unique case (state_q)
      RUN: begin
        if (coeff_fire) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd0) begin
            sym_valid_d = 1'b1;
            sym_d       = mk_sym(4'd0, dc_size, dc_amp, 1'b1, 1'b0);
            prev_dc_d   = coeff_in;
            zrun_d      = 6'd0;
          end else if (ac_sat == '0) begin
            if (idx_q == 6'd63) begin
              sym_valid_d = 1'b1;
              sym_d       = mk_sym(4'd0, 4'd0, 12'd0, 1'b0, 1'b1);
              zrun_d      = 6'd0;
            end else begin
              zrun_d = zrun_q + 6'd1;
            end
          end else if (zrun_q < 6'd16) begin
            sym_valid_d = 1'b1;
            sym_d       = mk_sym(zrun_q[3:0], ac_size, ac_amp, 1'b0, idx_q == 6'd63);
            zrun_d      = 6'd0;
          end else begin
            hold_size_d = ac_size;
            hold_amp_d  = ac_amp;
            hold_last_d = (idx_q == 6'd63);
            sym_valid_d = 1'b1;
            sym_d       = mk_sym(4'd15, 4'd0, 12'd0, 1'b0, 1'b0);
            zrun_d      = zrun_rem;
            state_d     = (zrun_rem >= 6'd16) ? ZRL_FLUSH : HELD;
          end
        end
      end
      ZRL_FLUSH: begin
        if (out_free) begin
          sym_valid_d = 1'b1;
          sym_d       = mk_sym(4'd15, 4'd0, 12'd0, 1'b0, 1'b0);
          zrun_d      = zrun_rem;
          state_d     = (zrun_rem >= 6'd16) ? ZRL_FLUSH : HELD;
        end
      end
      HELD: begin
        if (out_free) begin
          sym_valid_d = 1'b1;
          sym_d       = mk_sym(zrun_q[3:0], hold_size_q, hold_amp_q, 1'b0, hold_last_q);
          zrun_d      = 6'd0;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= RUN;
      idx_q       <= '0;
      zrun_q      <= '0;
      prev_dc_q   <= '0;
      hold_size_q <= '0;
      hold_amp_q  <= '0;
      hold_last_q <= 1'b0;
      sym_valid_q <= 1'b0;
      sym_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      zrun_q      <= zrun_d;
      prev_dc_q   <= prev_dc_d;
      hold_size_q <= hold_size_d;
      hold_amp_q  <= hold_amp_d;
      hold_last_q <= hold_last_d;
      sym_valid_q <= sym_valid_d;
      sym_q       <= sym_d;
    end
  end

  assign sym_valid_out = sym_valid_q;
  assign sym_run_out   = sym_q.run;
  assign sym_size_out  = sym_q.size;
  assign sym_amp_out   = sym_q.amp;
  assign sym_is_dc_out = sym_q.is_dc;
  assign sym_last_out  = sym_q.last;

endmodule

// File: tb/tb_rle_symbolizer.sv
// tb/tb_rle_symbolizer.sv - self-checking bench for rle_symbolizer
module tb_rle_symbolizer;

  logic               clk_in = 1'b0;
  logic               rst_n_in = 1'b0;
  logic               dc_clear_in = 1'b0;
  logic signed [10:0] coeff_in = '0;
  logic               coeff_valid_in = 1'b0;
  logic               coeff_ready_out;
  logic               sym_valid_out;
  logic               sym_ready_in = 1'b1;
  logic [3:0]         sym_run_out;
  logic [3:0]         sym_size_out;
  logic [11:0]        sym_amp_out;
  logic               sym_is_dc_out;
  logic               sym_last_out;

  rle_symbolizer #(.COEFF_W(11)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .dc_clear_in     (dc_clear_in),
    .coeff_in        (coeff_in),
    .coeff_valid_in  (coeff_valid_in),
    .coeff_ready_out (coeff_ready_out),
    .sym_valid_out   (sym_valid_out),
    .sym_ready_in    (sym_ready_in),
    .sym_run_out     (sym_run_out),
    .sym_size_out    (sym_size_out),
    .sym_amp_out     (sym_amp_out),
    .sym_is_dc_out   (sym_is_dc_out),
    .sym_last_out    (sym_last_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          blk;
    logic [21:0] sym;
  } vec_t;

  vec_t        vecs[$];
  logic [21:0] exp_q[$];
  logic [21:0] got_q[$];
  int          blk[64];
  int          total = 0;
  int          bad = 0;
  int          stall_cnt = 0;
  int          prev_dc_m = 0;
  bit          bp_en = 1'b0;
  bit          hold_chk = 1'b0;
  logic [22:0] snap = '0;
  int          exp_stall[7] = '{0, 0, 0, 2, 3, 0, 1};

  function automatic logic [21:0] pk(input int r, input int s, input int a,
                                     input int d, input int l);
    return {4'(r), 4'(s), 12'(a), 1'(d), 1'(l)};
  endfunction

  function automatic void addv(input int b, input int r, input int s,
                               input int a, input int d, input int l);
    vec_t v;
    v.blk = b;
    v.sym = pk(r, s, a, d, l);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, expv);
    end
  endtask

  // Reference model, written from the symbol rules.
  function automatic int cat_m(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a == 0) ? 0 : $clog2(a + 1);
  endfunction

  function automatic int amp_m(input int v, input int s);
    int m;
    m = (1 << s) - 1;
    return ((v >= 0) ? v : v - 1) & m;
  endfunction

  task automatic model_block();
    int d, z, v;
    d = blk[0] - prev_dc_m;
    exp_q.push_back(pk(0, cat_m(d), amp_m(d, cat_m(d)), 1, 0));
    prev_dc_m = blk[0];
    z = 0;
    for (int i = 1; i < 64; i++) begin
      v = (blk[i] > 1023) ? 1023 : (blk[i] < -1023) ? -1023 : blk[i];
      if (v == 0) begin
        if (i == 63) exp_q.push_back(pk(0, 0, 0, 0, 1));
        else z++;
      end else begin
        while (z >= 16) begin
          exp_q.push_back(pk(15, 0, 0, 0, 0));
          z -= 16;
        end
        exp_q.push_back(pk(z, cat_m(v), amp_m(v, cat_m(v)), 0, (i == 63) ? 1 : 0));
        z = 0;
      end
    end
  endtask

  task automatic build(input int b);
    for (int i = 0; i < 64; i++) blk[i] = 0;
    case (b)
      0: blk[0] = 5;
      1: blk[0] = -3;
      2: begin blk[0] = -3; blk[1] = -1; blk[3] = 7; end
      3: blk[41] = 1;
      4: begin blk[62] = -1024; blk[63] = 1000; end
      5: blk[0] = -1024;
      6: begin blk[0] = 1023; blk[17] = -2; end
      default: blk[0] = 4;
    endcase
  endtask

  task automatic send_block(input int n, input bit clr);
    int t;
    bit acc;
    for (int i = 0; i < n; i++) begin
      coeff_in       = 11'(blk[i]);
      coeff_valid_in = 1'b1;
      dc_clear_in    = clr && (i == 0);
      t   = 0;
      acc = 1'b0;
      while (!acc && t < 1000) begin
        @(negedge clk_in);
        acc = coeff_ready_out;
        @(posedge clk_in);
        #1;
        t++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    end
    coeff_valid_in = 1'b0;
    dc_clear_in    = 1'b0;
  endtask

  task automatic drain_compare(input string nm);
    int t;
    t = 0;
    while ((got_q.size() < exp_q.size() || sym_valid_out) && t < 2000) begin
      @(posedge clk_in);
      #1;
      t++;
    end
    repeat (3) @(posedge clk_in);
    #1;
    chk({nm, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk($sformatf("%s_sym%0d", nm, k), 32'(got_q[k]), 32'(exp_q[k]));
    got_q.delete();
    exp_q.delete();
  endtask

  always @(posedge clk_in) begin
    #1;
    sym_ready_in = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: collects handshaken symbols, checks stability under stall,
  // counts input stall cycles.
  always @(negedge clk_in) begin
    logic [22:0] cur;
    cur = {sym_valid_out, sym_run_out, sym_size_out, sym_amp_out, sym_is_dc_out, sym_last_out};
    if (rst_n_in) begin
      if (hold_chk) chk("stall_stable", 32'(cur), 32'(snap));
      hold_chk = sym_valid_out && !sym_ready_in;
      snap     = cur;
      if (sym_valid_out && sym_ready_in) got_q.push_back(cur[21:0]);
      if (coeff_valid_in && !coeff_ready_out) stall_cnt++;
    end else begin
      hold_chk = 1'b0;
    end
  end

  initial begin
    addv(0, 0, 3, 5, 1, 0);    addv(0, 0, 0, 0, 0, 1);
    addv(1, 0, 2, 0, 1, 0);    addv(1, 0, 0, 0, 0, 1);
    addv(2, 0, 0, 0, 1, 0);    addv(2, 0, 1, 0, 0, 0);
    addv(2, 1, 3, 7, 0, 0);    addv(2, 0, 0, 0, 0, 1);
    addv(3, 0, 2, 3, 1, 0);    addv(3, 15, 0, 0, 0, 0);
    addv(3, 15, 0, 0, 0, 0);   addv(3, 8, 1, 1, 0, 0);
    addv(3, 0, 0, 0, 0, 1);
    addv(4, 0, 0, 0, 1, 0);    addv(4, 15, 0, 0, 0, 0);
    addv(4, 15, 0, 0, 0, 0);   addv(4, 15, 0, 0, 0, 0);
    addv(4, 13, 10, 0, 0, 0);  addv(4, 0, 10, 1000, 0, 1);
    addv(5, 0, 11, 1023, 1, 0); addv(5, 0, 0, 0, 0, 1);
    addv(6, 0, 11, 2047, 1, 0); addv(6, 15, 0, 0, 0, 0);
    addv(6, 0, 2, 1, 0, 0);    addv(6, 0, 0, 0, 0, 1);

    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_outputs",
        32'({sym_valid_out, sym_run_out, sym_size_out, sym_amp_out, sym_is_dc_out, sym_last_out}),
        32'd0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("reset_ready", 32'(coeff_ready_out), 32'd1);
    @(posedge clk_in);
    #1;

    for (int b = 0; b < 7; b++) begin
      build(b);
      foreach (vecs[k]) if (vecs[k].blk == b) exp_q.push_back(vecs[k].sym);
      stall_cnt = 0;
      send_block(64, b == 1);
      chk($sformatf("blk%0d_stalls", b), stall_cnt, exp_stall[b]);
      drain_compare($sformatf("blk%0d", b));
    end

    // Reset in the middle of a block: the next coefficient is DC with prev 0.
    build(2);
    send_block(20, 1'b0);
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    got_q.delete();
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("midrst_ready", 32'(coeff_ready_out), 32'd1);
    chk("midrst_valid", 32'(sym_valid_out), 32'd0);
    @(posedge clk_in);
    #1;
    build(99);
    exp_q.push_back(pk(0, 3, 4, 1, 0));
    exp_q.push_back(pk(0, 0, 0, 0, 1));
    send_block(64, 1'b0);
    drain_compare("midrst");
    prev_dc_m = 4;

    // Random blocks under random backpressure against the model.
    bp_en = 1'b1;
    for (int b = 0; b < 20; b++) begin
      int r;
      blk[0] = int'($urandom_range(0, 2047)) - 1024;
      for (int i = 1; i < 64; i++) begin
        r = int'($urandom_range(0, 15));
        if (b % 4 == 3)  blk[i] = (i > 40 && r == 0) ? int'($urandom_range(0, 7)) - 3 : 0;
        else if (r == 0) blk[i] = int'($urandom_range(0, 2047)) - 1024;
        else if (r == 1) blk[i] = int'($urandom_range(0, 6)) - 3;
        else             blk[i] = 0;
      end
      model_block();
      send_block(64, 1'b0);
      drain_compare($sformatf("rnd%0d", b));
    end
    bp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
